// File: rtl/prog_ctrl_pkg.sv
// prog_ctrl_pkg
// Shared definitions for the programmable datapath controller:
//   state_e  - sequencer states (IDLE, CLEAR, EXEC, DONE)
//   opcode_e - 3-bit instruction opcodes
//   ALU_*    - encodings driven on s_o to select the ALU operation
package prog_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LDM  = 3'b001,
        OP_MOVA = 3'b010,
        OP_ADC  = 3'b011,
        OP_SBC  = 3'b100,
        OP_MOVR = 3'b101,
        OP_HALT = 3'b110,
        OP_RSV  = 3'b111
    } opcode_e;

    localparam logic [2:0] ALU_ADC   = 3'b000; // A + B + Cin
    localparam logic [2:0] ALU_SBC   = 3'b001; // A + ~B + Cin
    localparam logic [2:0] ALU_PASSB = 3'b010; // B

endpackage

// File: rtl/prog_ctrl_decode.sv
// prog_ctrl_decode
// Purely combinational decode of one instruction word into datapath controls.
// Ports:
//   instr_i   in  {opcode[2:0], operand[SELW-1:0]}
//   ce_o      out clock enables; bit NREG = accumulator A, bit k = Rk
//   w_o       out per-register load source: 0 = M[k], 1 = A
//   sel_o     out ALU B-operand select
//   s_o       out ALU operation
//   illegal_o out reserved opcode, or operand out of range on an operand opcode
//   halt_o    out HALT opcode
// An illegal word produces no datapath effect at all.
module prog_ctrl_decode
    import prog_ctrl_pkg::*;
#(
    parameter  int NREG = 3,
    localparam int SELW = $clog2(NREG + 1)
) (
    input  logic [SELW+2:0] instr_i,
    output logic [NREG:0]   ce_o,
    output logic [NREG-1:0] w_o,
    output logic [SELW-1:0] sel_o,
    output logic [2:0]      s_o,
    output logic            illegal_o,
    output logic            halt_o
);

    opcode_e         opcode;
    logic [SELW-1:0] operand;
    logic [NREG-1:0] k_hot;     // one-hot of the operand, all zero if out of range
    logic            operand_ok;

    assign opcode  = opcode_e'(instr_i[SELW+2:SELW]);
    assign operand = instr_i[SELW-1:0];

    for (genvar gi = 0; gi < NREG; gi++) begin : g_hot
        assign k_hot[gi] = (operand == SELW'(gi));
    end

    assign operand_ok = |k_hot;

    always_comb begin
        ce_o      = '0;
        w_o       = '0;
        sel_o     = '0;
        s_o       = ALU_ADC;
        illegal_o = 1'b0;
        halt_o    = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_LDM: begin
                ce_o[NREG-1:0] = '1;
            end
            OP_MOVA, OP_ADC, OP_SBC: begin
                if (operand_ok) begin
                    ce_o[NREG] = 1'b1;
                    sel_o      = operand;
                    s_o        = (opcode == OP_MOVA) ? ALU_PASSB :
                                 (opcode == OP_ADC)  ? ALU_ADC   : ALU_SBC;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OP_MOVR: begin
                if (operand_ok) begin
                    ce_o[NREG-1:0] = k_hot;
                    w_o            = k_hot;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OP_HALT: halt_o = 1'b1;
            default: illegal_o = 1'b1; // reserved opcode
        endcase
    end

endmodule

// File: rtl/prog_ctrl_seq.sv
// prog_ctrl_seq
// Steps through an external program one word per cycle and turns each word into
// datapath controls. start_i launches a run from pc=0 (only honoured in IDLE);
// done_o pulses for one cycle when the run ends (HALT or last program word).
// Ports:
//   clk, reset  clock (rising edge) and asynchronous active-high reset
//   start_i     launch request, sampled only in IDLE
//   pc_o        program address to the ROM; instr_i is the word at pc_o
//   busy_o      high in CLEAR and EXEC
//   done_o      one-cycle end-of-run pulse
//   err_o       sticky illegal-instruction flag, cleared when a start is accepted
//   clr_o       synchronous clear for all datapath registers (CLEAR state)
//   ce_o/w_o/sel_o/s_o  datapath controls decoded from instr_i during EXEC
// Controls are a combinational function of the state register and instr_i, so
// an asserted reset forces them to zero without waiting for a clock edge.
module prog_ctrl_seq
    import prog_ctrl_pkg::*;
#(
    parameter  int NREG       = 3,
    parameter  int PROG_DEPTH = 8,
    localparam int SELW       = $clog2(NREG + 1),
    localparam int AW         = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    output logic [AW-1:0]   pc_o,
    input  logic [SELW+2:0] instr_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic            clr_o,
    output logic [NREG:0]   ce_o,
    output logic [NREG-1:0] w_o,
    output logic [SELW-1:0] sel_o,
    output logic [2:0]      s_o
);

    localparam logic [AW-1:0] PC_LAST = AW'(PROG_DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          err_q, err_d;

    logic [NREG:0]   dec_ce;
    logic [NREG-1:0] dec_w;
    logic [SELW-1:0] dec_sel;
    logic [2:0]      dec_s;
    logic            dec_illegal;
    logic            dec_halt;
    logic            exec;

    prog_ctrl_decode #(
        .NREG (NREG)
    ) u_decode (
        .instr_i   (instr_i),
        .ce_o      (dec_ce),
        .w_o       (dec_w),
        .sel_o     (dec_sel),
        .s_o       (dec_s),
        .illegal_o (dec_illegal),
        .halt_o    (dec_halt)
    );

    assign exec = (state_q == ST_EXEC);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                pc_d = '0;
                if (start_i) begin
                    state_d = ST_CLEAR;
                    err_d   = 1'b0;
                end
            end
            ST_CLEAR: begin
                pc_d    = '0;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (dec_illegal) begin
                    err_d = 1'b1;
                end
                // The last word ends the run explicitly, so pc never wraps into
                // a second pass even when PROG_DEPTH is not a power of two.
                if (dec_halt || (pc_q == PC_LAST)) begin
                    state_d = ST_DONE;
                    pc_d    = '0;
                end else begin
                    pc_d = pc_q + AW'(1);
                end
            end
            ST_DONE: begin
                pc_d    = '0;
                state_d = ST_IDLE;
            end
            default: begin
                pc_d    = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

    assign pc_o   = pc_q;
    assign busy_o = (state_q == ST_CLEAR) || exec;
    assign done_o = (state_q == ST_DONE);
    assign clr_o  = (state_q == ST_CLEAR);
    // An illegal word is flagged in the cycle it executes, then held by err_q.
    assign err_o  = err_q || (exec && dec_illegal);
    assign ce_o   = exec ? dec_ce  : '0;
    assign w_o    = exec ? dec_w   : '0;
    assign sel_o  = exec ? dec_sel : '0;
    assign s_o    = exec ? dec_s   : '0;

endmodule

// File: tb/tb_prog_ctrl_seq.sv
// Bench for prog_ctrl_seq: a reference model turns each ROM program into the
// expected per-cycle output sequence, queued before start; the DUT outputs are
// popped and compared every cycle on the falling edge.
module tb_prog_ctrl_seq;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---- instance 1: NREG=3, PROG_DEPTH=8 ----
    logic       start_i = 1'b0;
    logic [2:0] pc_o;
    logic [4:0] instr_i;
    logic       busy_o, done_o, err_o, clr_o;
    logic [3:0] ce_o;
    logic [2:0] w_o;
    logic [1:0] sel_o;
    logic [2:0] s_o;
    logic [4:0] rom [0:7];

    assign instr_i = rom[pc_o];

    prog_ctrl_seq #(.NREG(3), .PROG_DEPTH(8)) u_dut (
        .clk(clk), .reset(reset), .start_i(start_i), .pc_o(pc_o), .instr_i(instr_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .clr_o(clr_o),
        .ce_o(ce_o), .w_o(w_o), .sel_o(sel_o), .s_o(s_o)
    );

    // ---- instance 2: NREG=5, PROG_DEPTH=16 ----
    logic       start2 = 1'b0;
    logic [3:0] pc2;
    logic [5:0] instr2;
    logic       busy2, done2, err2, clr2;
    logic [5:0] ce2;
    logic [4:0] w2;
    logic [2:0] sel2;
    logic [2:0] s2;
    logic [5:0] rom2 [0:15];

    assign instr2 = rom2[pc2];

    prog_ctrl_seq #(.NREG(5), .PROG_DEPTH(16)) u_dut5 (
        .clk(clk), .reset(reset), .start_i(start2), .pc_o(pc2), .instr_i(instr2),
        .busy_o(busy2), .done_o(done2), .err_o(err2), .clr_o(clr2),
        .ce_o(ce2), .w_o(w2), .sel_o(sel2), .s_o(s2)
    );

    typedef struct packed {
        logic       clr;
        logic       busy;
        logic       done;
        logic       err;
        logic [2:0] pc;
        logic [3:0] ce;
        logic [2:0] w;
        logic [1:0] sel;
        logic [2:0] s;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference decode for NREG=3, written from the opcode table.
    task automatic model_dec(input logic [4:0] word, output exp_t r,
                             output logic ill, output logic halt);
        logic [2:0] op;
        logic [1:0] k;
        op   = word[4:2];
        k    = word[1:0];
        r    = '0;
        ill  = 1'b0;
        halt = 1'b0;
        case (op)
            3'b001: r.ce = 4'b0111;
            3'b010, 3'b011, 3'b100: begin
                if (k == 2'd3) ill = 1'b1;
                else begin
                    r.ce  = 4'b1000;
                    r.sel = k;
                    r.s   = (op == 3'b010) ? 3'b010 : (op == 3'b011) ? 3'b000 : 3'b001;
                end
            end
            3'b101: begin
                if (k == 2'd3) ill = 1'b1;
                else begin
                    r.ce = 4'b0001 << k;
                    r.w  = 3'b001 << k;
                end
            end
            3'b110: halt = 1'b1;
            3'b111: ill = 1'b1;
            default: ;
        endcase
    endtask

    task automatic cmp_rec(input exp_t r);
        chk("clr",  32'(clr_o),  32'(r.clr));
        chk("busy", 32'(busy_o), 32'(r.busy));
        chk("done", 32'(done_o), 32'(r.done));
        chk("err",  32'(err_o),  32'(r.err));
        chk("pc",   32'(pc_o),   32'(r.pc));
        chk("ce",   32'(ce_o),   32'(r.ce));
        chk("w",    32'(w_o),    32'(r.w));
        chk("sel",  32'(sel_o),  32'(r.sel));
        chk("s",    32'(s_o),    32'(r.s));
    endtask

    // reps>1 holds start_i high for back-to-back runs; pulse_at raises start_i
    // for one cycle at that record index; exp_done>0 checks start->done latency.
    task automatic run_prog(input string name, input int reps, input int pulse_at,
                            input int exp_done);
        exp_t r;
        logic ill, halt, err_acc;
        int   last_clear, i, done_cyc;
        exp_q.delete();
        last_clear = 0;
        for (int rep = 0; rep < reps; rep++) begin
            err_acc    = 1'b0;
            last_clear = exp_q.size();
            r = '0; r.clr = 1'b1; r.busy = 1'b1;
            exp_q.push_back(r);
            for (int p = 0; p < 8; p++) begin
                model_dec(rom[p], r, ill, halt);
                err_acc = err_acc | ill;
                r.busy = 1'b1;
                r.pc   = 3'(p);
                r.err  = err_acc;
                exp_q.push_back(r);
                if (halt) break;
            end
            r = '0; r.done = 1'b1; r.err = err_acc;
            exp_q.push_back(r);
            r = '0; r.err = err_acc;   // one IDLE cycle
            exp_q.push_back(r);
        end
        @(negedge clk);
        start_i = 1'b1;
        i = 0;
        done_cyc = -1;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            r = exp_q.pop_front();
            cmp_rec(r);
            if (done_o && done_cyc < 0) done_cyc = i + 1;
            start_i = (i < last_clear) || (i == pulse_at);
            i++;
        end
        start_i = 1'b0;
        if (exp_done > 0) chk("done_cycle", 32'(done_cyc), 32'(exp_done));
        $display("run %s reps=%0d cycles=%0d done_at=%0d errors_so_far=%0d",
                 name, reps, i, done_cyc, n_err);
    endtask

    task automatic load_rom(input logic [39:0] words);
        for (int p = 0; p < 8; p++) rom[p] = words[39 - 5*p -: 5];
    endtask

    initial begin
        load_rom('0);
        for (int p = 0; p < 16; p++) rom2[p] = 6'b000_000;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_ce",   32'(ce_o),   32'd0);
        chk("rst_clr",  32'(clr_o),  32'd0);
        chk("rst_pc",   32'(pc_o),   32'd0);
        chk("rst_err",  32'(err_o),  32'd0);
        $display("reset state checked");

        // LDM, MOVA R0, SBC R1, MOVR R2, HALT
        load_rom({5'b001_00, 5'b010_00, 5'b100_01, 5'b101_10, 5'b110_00,
                  5'b000_00, 5'b000_00, 5'b000_00});
        run_prog("progA", 1, -1, 7);
        run_prog("progA_pulse", 1, 3, 7);
        run_prog("progA_held", 2, -1, 7);

        // No HALT: all eight words execute
        load_rom({5'b001_00, 5'b011_10, 5'b010_01, 5'b101_00, 5'b000_00,
                  5'b100_00, 5'b101_01, 5'b011_01});
        run_prog("noHalt", 1, -1, 10);

        // MOVA R3 (out of range), ADC R0, reserved opcode, HALT; second run shows clear
        load_rom({5'b010_11, 5'b011_00, 5'b111_00, 5'b110_00, 5'b000_00,
                  5'b000_00, 5'b000_00, 5'b000_00});
        run_prog("illegal", 2, -1, 6);

        // Reset in the middle of EXEC
        load_rom({5'b001_00, 5'b010_00, 5'b100_01, 5'b101_10, 5'b110_00,
                  5'b000_00, 5'b000_00, 5'b000_00});
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy_o), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_ce",   32'(ce_o),   32'd0);
        chk("arst_clr",  32'(clr_o),  32'd0);
        chk("arst_pc",   32'(pc_o),   32'd0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy_o), 32'd0);
        chk("post_rst_pc",   32'(pc_o),   32'd0);
        $display("reset mid-EXEC checked");

        // NREG=5 instance: ADC R4, MOVA R5 (illegal), HALT
        rom2[0] = 6'b011_100;
        rom2[1] = 6'b010_101;
        rom2[2] = 6'b110_000;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        chk("n5_clr", 32'(clr2), 32'd1);
        @(negedge clk);
        chk("n5_ce",  32'(ce2),  32'b100000);
        chk("n5_sel", 32'(sel2), 32'd4);
        chk("n5_s",   32'(s2),   32'd0);
        chk("n5_err0", 32'(err2), 32'd0);
        @(negedge clk);
        chk("n5_ill_ce", 32'(ce2), 32'd0);
        chk("n5_err1",   32'(err2), 32'd1);
        chk("n5_pc",     32'(pc2),  32'd1);
        @(negedge clk);
        chk("n5_halt_ce", 32'(ce2), 32'd0);
        @(negedge clk);
        chk("n5_done", 32'(done2), 32'd1);
        chk("n5_err_done", 32'(err2), 32'd1);
        $display("nreg5 run checked");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
